// File: rtl/sudoku_grid_loader_if.sv
// ============================================================================
// Module  : sudoku_grid_loader_if
// Purpose : Grid RAM port and solver req/ack handoff between loader and solver.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sudoku_grid_loader_if #(
    parameter int ADDR_W = 7
) ();
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [3:0]        MemWData;
    logic [3:0]        MemRData;
    logic              SolveReq;
    logic              SolveAck;

    modport master (
        output MemWe, MemAddr, MemWData, SolveReq,
        input  MemRData, SolveAck
    );

    modport slave (
        input  MemWe, MemAddr, MemWData, SolveReq,
        output MemRData, SolveAck
    );
endinterface

`default_nettype wire

// File: rtl/sudoku_grid_loader.sv
// ============================================================================
// Module  : sudoku_grid_loader
// Purpose : Button-driven cursor/cell writer for the 81-cell puzzle RAM with
//           solver handoff.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sudoku_grid_loader #(
    parameter int N      = 9,
    parameter int CELLS  = 81,
    parameter int ADDR_W = 7
) (
    input  wire logic       board_clk,
    input  wire logic       Reset,
    input  wire logic       Prev,
    input  wire logic       Next,
    input  wire logic       Enter,
    input  wire logic       Start,
    input  wire logic [3:0] InputValue,
    output logic      [3:0] Row,
    output logic      [3:0] Col,
    output logic      [3:0] CurValue,
    output logic            Busy,
    output logic            Err,
    sudoku_grid_loader_if.master bus
);

    localparam logic [2:0] ST_CLEAR   = 3'd0;
    localparam logic [2:0] ST_EDIT    = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_HANDOFF = 3'd3;
    localparam logic [2:0] ST_LOCKED  = 3'd4;

    localparam logic [3:0]        LAST_IDX  = 4'(N - 1);
    localparam logic [3:0]        MAX_DIGIT = 4'(N);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [3:0]        wr_val;
    logic [3:0]        fwd_row, fwd_col, bwd_row, bwd_col;
    logic [3:0]        nxt_row, nxt_col;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] r, input logic [3:0] c);
        return ADDR_W'(r) * ADDR_W'(N) + ADDR_W'(c);
    endfunction

    always_comb begin
        fwd_row = Row;
        fwd_col = Col + 4'd1;
        if (Col == LAST_IDX) begin
            fwd_col = 4'd0;
            fwd_row = (Row == LAST_IDX) ? 4'd0 : Row + 4'd1;
        end
        bwd_row = Row;
        bwd_col = Col - 4'd1;
        if (Col == 4'd0) begin
            bwd_col = LAST_IDX;
            bwd_row = (Row == 4'd0) ? LAST_IDX : Row - 4'd1;
        end
    end

    // Cursor next-state; Start and Enter outrank movement in EDIT.
    always_comb begin
        nxt_row = Row;
        nxt_col = Col;
        case (state)
            ST_EDIT: begin
                if (!Start && !Enter) begin
                    if (Next) begin
                        nxt_row = fwd_row;
                        nxt_col = fwd_col;
                    end else if (Prev) begin
                        nxt_row = bwd_row;
                        nxt_col = bwd_col;
                    end
                end
            end
            ST_WRITE: begin
                nxt_row = fwd_row;
                nxt_col = fwd_col;
            end
            ST_LOCKED: begin
                if (Start) begin
                    nxt_row = 4'd0;
                    nxt_col = 4'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state        <= ST_CLEAR;
            clr_cnt      <= '0;
            wr_val       <= 4'd0;
            Row          <= 4'd0;
            Col          <= 4'd0;
            CurValue     <= 4'd0;
            Busy         <= 1'b1;
            Err          <= 1'b0;
            bus.MemWe    <= 1'b0;
            bus.MemAddr  <= '0;
            bus.MemWData <= 4'd0;
            bus.SolveReq <= 1'b0;
        end else begin
            Row <= nxt_row;
            Col <= nxt_col;
            case (state)
                ST_CLEAR: begin
                    bus.MemWe    <= 1'b1;
                    bus.MemAddr  <= clr_cnt;
                    bus.MemWData <= 4'd0;
                    Busy         <= 1'b1;
                    if (clr_cnt == LAST_CELL) begin
                        clr_cnt <= '0;
                        state   <= ST_EDIT;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_EDIT: begin
                    // Address follows the new cursor so CurValue lags it by two cycles.
                    bus.MemWe   <= 1'b0;
                    bus.MemAddr <= cell_addr(nxt_row, nxt_col);
                    CurValue    <= bus.MemRData;
                    Busy        <= 1'b0;
                    if (Start) begin
                        state <= ST_HANDOFF;
                    end else if (Enter) begin
                        if (InputValue <= MAX_DIGIT) begin
                            wr_val <= InputValue;
                            Err    <= 1'b0;
                            state  <= ST_WRITE;
                        end else begin
                            Err <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    bus.MemWe    <= 1'b1;
                    bus.MemAddr  <= cell_addr(Row, Col);
                    bus.MemWData <= wr_val;
                    Busy         <= 1'b1;
                    state        <= ST_EDIT;
                end
                ST_HANDOFF: begin
                    bus.MemWe <= 1'b0;
                    Busy      <= 1'b1;
                    if (bus.SolveReq && bus.SolveAck) begin
                        bus.SolveReq <= 1'b0;
                        state        <= ST_LOCKED;
                    end else begin
                        bus.SolveReq <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    bus.MemWe <= 1'b0;
                    Busy      <= 1'b0;
                    if (Start) begin
                        clr_cnt <= '0;
                        state   <= ST_CLEAR;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sudoku_grid_loader.sv
// ============================================================================
// Module  : tb_sudoku_grid_loader
// Purpose : Directed self-checking bench for sudoku_grid_loader with a RAM model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sudoku_grid_loader;

    logic       board_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Prev = 1'b0, Next = 1'b0, Enter = 1'b0, Start = 1'b0;
    logic [3:0] InputValue = 4'd0;
    logic [3:0] Row, Col, CurValue;
    logic       Busy, Err;
    int         errors = 0;
    int         checks = 0;
    logic [3:0] mem [0:127];

    sudoku_grid_loader_if #(.ADDR_W(7)) bus ();

    sudoku_grid_loader #(.N(9), .CELLS(81), .ADDR_W(7)) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .Prev      (Prev),
        .Next      (Next),
        .Enter     (Enter),
        .Start     (Start),
        .InputValue(InputValue),
        .Row       (Row),
        .Col       (Col),
        .CurValue  (CurValue),
        .Busy      (Busy),
        .Err       (Err),
        .bus       (bus)
    );

    always #5 board_clk = ~board_clk;

    // Synchronous-read RAM: data for an address appears one cycle later.
    initial begin
        for (int a = 0; a < 128; a++) mem[a] = 4'(a % 7 + 3);
        bus.MemRData = 4'd0;
        bus.SolveAck = 1'b0;
    end
    always @(posedge board_clk) begin
        if (bus.MemWe === 1'b1) mem[bus.MemAddr] <= bus.MemWData;
        bus.MemRData <= mem[bus.MemAddr];
    end

    task automatic step();
        @(posedge board_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_next();
        Next = 1'b1; step(); Next = 1'b0;
    endtask

    task automatic pulse_prev();
        Prev = 1'b1; step(); Prev = 1'b0;
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("clear_we", bus.MemWe, 1);
            chk("clear_addr", bus.MemAddr, i);
            chk("clear_wdata", bus.MemWData, 0);
            chk("clear_busy", Busy, 1);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"}, bus.MemWe, 0);
        chk({tag, "_addr"}, bus.MemAddr, 0);
        chk({tag, "_wdata"}, bus.MemWData, 0);
        chk({tag, "_req"}, bus.SolveReq, 0);
        chk({tag, "_busy"}, Busy, 1);
        chk({tag, "_err"}, Err, 0);
        chk({tag, "_row"}, Row, 0);
        chk({tag, "_col"}, Col, 0);
        chk({tag, "_cur"}, CurValue, 0);
    endtask

    initial begin
        step(); step();
        chk_reset_vals("reset");
        Reset = 1'b0;

        sweep(81);
        step();
        chk("edit_busy", Busy, 0);
        chk("edit_we", bus.MemWe, 0);
        chk("edit_addr", bus.MemAddr, 0);
        step(); step();
        chk("edit_cur0", CurValue, 0);

        // Valid Enter at (0,0)
        InputValue = 4'd5; Enter = 1'b1; step(); Enter = 1'b0;
        chk("enter_no_we_yet", bus.MemWe, 0);
        step();
        chk("wr_we", bus.MemWe, 1);
        chk("wr_addr", bus.MemAddr, 0);
        chk("wr_data", bus.MemWData, 5);
        chk("wr_row", Row, 0);
        chk("wr_col", Col, 1);
        step();
        chk("wr_we_off", bus.MemWe, 0);
        chk("wr_addr_next", bus.MemAddr, 1);
        step(); step();
        chk("cur_at_1", CurValue, 0);

        // Read back the written 5 with the two-cycle lag
        pulse_prev();
        chk("prev_col", Col, 0);
        chk("prev_addr", bus.MemAddr, 0);
        step();
        chk("cur_lag1", CurValue, 0);
        step();
        chk("cur_lag2", CurValue, 5);

        // Wrap corners
        pulse_prev();
        chk("wrap_prev_row", Row, 8);
        chk("wrap_prev_col", Col, 8);
        chk("wrap_prev_addr", bus.MemAddr, 80);
        pulse_next();
        chk("wrap_next_row", Row, 0);
        chk("wrap_next_col", Col, 0);
        chk("wrap_next_addr", bus.MemAddr, 0);
        pulse_prev();
        chk("wrap_again_addr", bus.MemAddr, 80);
        pulse_next();
        for (int k = 0; k < 27; k++) pulse_next();
        chk("at30_row", Row, 3);
        chk("at30_col", Col, 0);
        chk("at30_addr", bus.MemAddr, 27);
        pulse_prev();
        chk("row_back_row", Row, 2);
        chk("row_back_col", Col, 8);
        chk("row_back_addr", bus.MemAddr, 26);

        // Next beats Prev when coincident
        Next = 1'b1; Prev = 1'b1; step(); Next = 1'b0; Prev = 1'b0;
        chk("prio_np_row", Row, 3);
        chk("prio_np_col", Col, 0);
        pulse_prev();

        // Invalid entry sets Err, no write
        InputValue = 4'd12; Enter = 1'b1; step(); Enter = 1'b0;
        chk("bad_err", Err, 1);
        chk("bad_we", bus.MemWe, 0);
        step();
        chk("bad_we2", bus.MemWe, 0);
        chk("bad_col", Col, 8);
        step();
        chk("err_sticky", Err, 1);

        // Blank entry is valid and clears Err
        InputValue = 4'd0; Enter = 1'b1; step(); Enter = 1'b0;
        chk("blank_err", Err, 0);
        step();
        chk("blank_we", bus.MemWe, 1);
        chk("blank_addr", bus.MemAddr, 26);
        chk("blank_data", bus.MemWData, 0);
        chk("blank_row", Row, 3);
        chk("blank_col", Col, 0);
        step();

        // Start and Enter together: handoff, no write
        InputValue = 4'd7; Start = 1'b1; Enter = 1'b1; step(); Start = 1'b0; Enter = 1'b0;
        chk("se_we", bus.MemWe, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("ho_req", bus.SolveReq, 1);
            chk("ho_we", bus.MemWe, 0);
            chk("ho_busy", Busy, 1);
        end
        pulse_next();
        chk("ho_next_ignored", Col, 0);
        chk("ho_req_held", bus.SolveReq, 1);
        bus.SolveAck = 1'b1; step(); bus.SolveAck = 1'b0;
        chk("ack_req_drop", bus.SolveReq, 0);
        step();
        chk("locked_busy", Busy, 0);
        chk("locked_we", bus.MemWe, 0);
        pulse_next();
        pulse_next();
        chk("locked_row", Row, 3);
        chk("locked_col", Col, 0);
        Start = 1'b1; step(); Start = 1'b0;
        chk("unlock_row", Row, 0);
        chk("unlock_col", Col, 0);
        sweep(81);
        step();
        chk("reclear_busy", Busy, 0);
        step(); step();
        chk("cleared_cur", CurValue, 0);

        // Reset mid-handoff
        pulse_next();
        pulse_next();
        chk("pre_rst_col", Col, 2);
        Start = 1'b1; step(); Start = 1'b0;
        step();
        chk("pre_rst_req", bus.SolveReq, 1);
        #2 Reset = 1'b1;
        #1 chk_reset_vals("rst_ho");
        @(posedge board_clk); #1 Reset = 1'b0;

        // Reset mid-clear at clr_cnt = 40
        sweep(40);
        #2 Reset = 1'b1;
        #1 chk_reset_vals("rst_clr");
        @(posedge board_clk); #1 Reset = 1'b0;
        sweep(81);
        step();
        chk("final_busy", Busy, 0);
        chk("final_we", bus.MemWe, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
